// File: rtl/cpu_debug_sequencer_pkg.sv
// Shared definitions for the CPU run-control / state-dump sequencer and its consumers
// (display or UART formatter): state encodings, scan depths and tag layout.
package cpu_debug_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_SET,
    S_SAMPLE,
    S_PRESENT,
    S_DONE
  } state_t;

  localparam int RF_DEPTH_C = 4;
  localparam int DM_DEPTH_C = 16;
  localparam int TAG_W      = 5;
  localparam int IS_DM_BIT  = 4;

  // Tag layout: {is_dm, addr[3:0]}; register-file items keep addr[3:2] at zero.
  function automatic logic [TAG_W-1:0] item_tag(input logic is_dm, input logic [3:0] addr);
    logic [TAG_W-1:0] t;
    t            = {1'b0, addr};
    t[IS_DM_BIT] = is_dm;
    return t;
  endfunction

endpackage

// File: rtl/cpu_debug_sequencer_run_watchdog.sv
// Cycle watchdog for the RUN phase: counts enabled cycles since the last clear and
// flags the cycle on which the TIMEOUT-th enabled cycle is being spent.
module cpu_debug_sequencer_run_watchdog #(
  parameter int TIMEOUT = 65535,
  localparam int CW     = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clear_i)
      count_q <= '0;
    else if (en_i && count_q != CW'(TIMEOUT))
      count_q <= count_q + 1'b1;
  end

  assign expired_o = en_i && (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_debug_sequencer.sv
// Run-control and state-dump sequencer: pulses CPU start, waits for a fresh halt, then streams
// all register-file and data-memory words out over a valid/ready byte link.
module cpu_debug_sequencer
  import cpu_debug_sequencer_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int RF_DEPTH = RF_DEPTH_C,
  parameter int DM_DEPTH = DM_DEPTH_C,
  parameter int TIMEOUT  = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_req,
  input  logic              scan_req,
  output logic              cpu_start,
  input  logic              cpu_stopped,
  output logic [1:0]        dbg_rf_addr,
  output logic [3:0]        dbg_dm_addr,
  input  logic [DATA_W-1:0] dbg_rf_data,
  input  logic [DATA_W-1:0] dbg_dm_data,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              timed_out
);

  localparam int N_ITEMS = RF_DEPTH + DM_DEPTH;
  localparam int IDX_W   = $clog2(N_ITEMS);
  localparam logic [IDX_W-1:0] RF_N     = IDX_W'(RF_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ITEMS - 1);

  state_t              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic                armed_q;
  logic                cpu_start_q, busy_q, done_q, timed_out_q, valid_q;
  logic [1:0]          rf_addr_q;
  logic [3:0]          dm_addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [TAG_W-1:0]    tag_q;

  logic                is_rf;
  logic [3:0]          dm_idx;
  logic                wd_clear, wd_en, wd_expired;

  assign is_rf    = (idx_q < RF_N);
  assign dm_idx   = 4'(idx_q - RF_N);
  assign wd_clear = (state_q == S_START);
  assign wd_en    = (state_q == S_RUN);

  cpu_debug_sequencer_run_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (wd_clear),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      armed_q     <= 1'b0;
      cpu_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
      valid_q     <= 1'b0;
      rf_addr_q   <= '0;
      dm_addr_q   <= '0;
      data_q      <= '0;
      tag_q       <= '0;
    end else begin
      cpu_start_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (run_req) begin
            state_q     <= S_START;
            cpu_start_q <= 1'b1;
            busy_q      <= 1'b1;
            timed_out_q <= 1'b0;
          end else if (scan_req) begin
            state_q     <= S_SET;
            idx_q       <= '0;
            busy_q      <= 1'b1;
            timed_out_q <= 1'b0;
          end
        end
        S_START: begin
          armed_q <= 1'b0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          // A stopped flag only counts once the CPU has been seen running this time.
          if (!cpu_stopped) armed_q <= 1'b1;
          if (armed_q && cpu_stopped) begin
            state_q <= S_SET;
            idx_q   <= '0;
          end else if (wd_expired) begin
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            timed_out_q <= 1'b1;
          end
        end
        S_SET: begin
          if (is_rf) rf_addr_q <= idx_q[1:0];
          else       dm_addr_q <= dm_idx;
          state_q <= S_SAMPLE;
        end
        S_SAMPLE: begin
          data_q  <= is_rf ? dbg_rf_data : dbg_dm_data;
          tag_q   <= is_rf ? item_tag(1'b0, {2'b00, idx_q[1:0]}) : item_tag(1'b1, dm_idx);
          valid_q <= 1'b1;
          state_q <= S_PRESENT;
        end
        S_PRESENT: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= S_SET;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_start   = cpu_start_q;
  assign dbg_rf_addr = rf_addr_q;
  assign dbg_dm_addr = dm_addr_q;
  assign out_data    = data_q;
  assign out_tag     = tag_q;
  assign out_valid   = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timed_out   = timed_out_q;

endmodule
